hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REDIRECT_BUBBLES, default 1: cycles of decode/execute flush after a redirect, legal range 1..7.
REQ-002 SHALL have port clk, input, 1 bit: the single core clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port dec_valid, input, 1 bit: the decode stage holds a real instruction.
REQ-005 SHALL have ports dec_adr1 and dec_adr2, input, 5 bits each: decoded source addresses; value 0 means unused or x0.
REQ-006 SHALL have ports ex_valid, ex_rd (5 bits) and ex_is_load, input: execute-stage writer, its destination and its load flag.
REQ-007 SHALL have ports wb_valid and wb_rd (5 bits), input: writeback-stage writer and its destination.
REQ-008 SHALL have ports ex_redirect and mem_busy, input, 1 bit each: taken branch or jump resolved in execute; data memory not ready.
REQ-009 SHALL have outputs stall_f, stall_d, flush_d and flush_x, 1 bit each: hold fetch, hold decode, bubble decode, bubble execute.
REQ-010 SHALL have outputs fwd_a and fwd_b, 2 bits each: operand source select, 00 = regfile, 01 = EX result, 10 = WB result.
REQ-011 SHALL have outputs stall_cnt and flush_cnt, 32 bits each: performance counters (see Configuration).

Function
REQ-012 SHALL implement FSM states RUN, LD_STALL, FLUSH and MEM_WAIT, and reset to RUN.
REQ-013 SHALL define match_a = (dec_adr1 != 0) and (dec_adr1 == rd) for a stage's rd and valid; match_b is the same with dec_adr2.
REQ-014 SHALL drive fwd_a to 01 on an EX match with !ex_is_load, else 10 on a WB match, else 00; EX has priority over WB; fwd_b is the same.
REQ-015 In RUN, a load-use hazard (dec_valid, ex_valid, ex_is_load, and an EX match on either source) SHALL assert stall_f, stall_d and flush_x combinationally in the same cycle, then go to LD_STALL.
REQ-016 LD_STALL SHALL last exactly one cycle with no stall, letting WB forwarding resolve the load, then return to RUN; a back-to-back load-use stall SHALL never occur.
REQ-017 ex_redirect in RUN or LD_STALL SHALL assert flush_d and flush_x that cycle, load the bubble counter with REDIRECT_BUBBLES-1, and go to FLUSH if the loaded value is nonzero.
REQ-018 FLUSH SHALL assert flush_d and flush_x, decrement the counter each cycle, and return to RUN when the counter reaches 0.
REQ-019 mem_busy SHALL have top priority: stall_f and stall_d asserted, flushes deasserted, state moved to MEM_WAIT with the prior state and counter saved and frozen.
REQ-020 MEM_WAIT SHALL restore the saved state on the first cycle mem_busy is low.
REQ-021 Redirect SHALL have priority over load-use in the same cycle: flush only, no stall.
REQ-022 Simultaneous redirect and mem_busy SHALL enter MEM_WAIT; upstream holds ex_redirect stable, so the redirect is taken on exit.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state RUN, counter 0, all stalls and flushes 0, fwd 00 and perf counters 0, including mid-FLUSH or mid-MEM_WAIT.

Configuration
REQ-024 With HAZARD_PERF_EN defined, stall_cnt SHALL increment on each stall_d cycle and flush_cnt on each flush_d cycle, both wrapping at 2^32; without it, both SHALL be constant 0 and the counter registers SHALL be absent.

Structure
REQ-025 The fwd select encodings and FSM state encodings SHALL live in the shared defines header beside the existing XLEN and opcode constants.
REQ-026 Source matching SHALL be one sub-module, hazard_match (adr, rd, valid -> hit), instantiated four times.

Verification
REQ-027 lw x5 in EX, add x6,x5,x7 in decode -> 1-cycle stall_f/stall_d/flush_x, then fwd_a=10 in LD_STALL, then RUN.
REQ-028 addi x5 in EX, sub x8,x9,x5 in decode -> no stall, fwd_b=01, fwd_a=00.
REQ-029 ex_redirect=1 with REDIRECT_BUBBLES=3 -> flush_d/flush_x high for exactly 3 cycles.
REQ-030 mem_busy high for 4 cycles during FLUSH cycle 2 -> stalls held 4 cycles, flush resumes with the remaining count.
REQ-031 dec_adr1=0 with ex_rd=0 load -> no stall, fwd_a=00.
REQ-032 rst_n low mid-FLUSH -> all outputs 0 asynchronously; with HAZARD_PERF_EN, stall_cnt=0 after reset.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared core defines (XLEN, opcodes, forward selects, hazard FSM states)
package hazard_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LD_STALL,
        ST_FLUSH,
        ST_MEM_WAIT
    } state_e;

endpackage

// File: rtl/hazard_match.sv
// hazard_match: one decode source against one stage destination; x0 never matches
module hazard_match (
    input  logic [4:0] adr,
    input  logic [4:0] rd,
    input  logic       valid,
    output logic       hit
);

    assign hit = valid && (adr != 5'd0) && (adr == rd);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, redirect flush, memory wait and operand forwarding; HAZARD_PERF_EN adds stall/flush counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dec_valid,
    input  logic [4:0]      dec_adr1,
    input  logic [4:0]      dec_adr2,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_is_load,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            ex_redirect,
    input  logic            mem_busy,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_x,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [XLEN-1:0] stall_cnt,
    output logic [XLEN-1:0] flush_cnt
);

    localparam logic [2:0] RB_M1 = 3'(REDIRECT_BUBBLES - 1);

    logic   ex_a, ex_b, wb_a, wb_b, load_use;
    logic   sf, sd, fd, fx;
    logic   [2:0] cnt_q, cnt_d;
    state_e state_q, state_d, sv_q, sv_d, eff;

    hazard_match u_ex_a (.adr(dec_adr1), .rd(ex_rd), .valid(ex_valid), .hit(ex_a));
    hazard_match u_ex_b (.adr(dec_adr2), .rd(ex_rd), .valid(ex_valid), .hit(ex_b));
    hazard_match u_wb_a (.adr(dec_adr1), .rd(wb_rd), .valid(wb_valid), .hit(wb_a));
    hazard_match u_wb_b (.adr(dec_adr2), .rd(wb_rd), .valid(wb_valid), .hit(wb_b));

    assign load_use = dec_valid && ex_is_load && (ex_a || ex_b);

    // Forward select: a non-load EX result beats WB; everything reads 00 while in reset
    always_comb begin
        fwd_a = !rst_n ? FWD_RF : (ex_a && !ex_is_load) ? FWD_EX : wb_a ? FWD_WB : FWD_RF;
        fwd_b = !rst_n ? FWD_RF : (ex_b && !ex_is_load) ? FWD_EX : wb_b ? FWD_WB : FWD_RF;
    end

    // Next state: MEM_WAIT acts as its saved state on the first non-busy cycle
    always_comb begin
        state_d = state_q;
        sv_d    = sv_q;
        cnt_d   = cnt_q;
        sf      = 1'b0;
        sd      = 1'b0;
        fd      = 1'b0;
        fx      = 1'b0;
        eff     = (state_q == ST_MEM_WAIT) ? sv_q : state_q;
        if (mem_busy) begin
            sf      = 1'b1;
            sd      = 1'b1;
            sv_d    = eff;
            state_d = ST_MEM_WAIT;
        end else if (eff == ST_FLUSH) begin
            fd      = 1'b1;
            fx      = 1'b1;
            cnt_d   = cnt_q - 3'd1;
            state_d = (cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (ex_redirect) begin
            fd      = 1'b1;
            fx      = 1'b1;
            cnt_d   = RB_M1;
            state_d = (RB_M1 != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (eff == ST_RUN && load_use) begin
            sf      = 1'b1;
            sd      = 1'b1;
            fx      = 1'b1;
            state_d = ST_LD_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    assign stall_f = rst_n & sf;
    assign stall_d = rst_n & sd;
    assign flush_d = rst_n & fd;
    assign flush_x = rst_n & fx;

    // FSM state, saved state and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            sv_q    <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            sv_q    <= sv_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Counters wrap naturally at 2^XLEN
    always_comb begin
        stall_cnt_d = stall_cnt_q + XLEN'(sd);
        flush_cnt_d = flush_cnt_q + XLEN'(fd);
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random traffic against a cycle-level hazard model
module tb_hazard_ctrl;

    localparam int RB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, ex_valid, ex_is_load, wb_valid, ex_redirect, mem_busy;
    logic [4:0]  dec_adr1, dec_adr2, ex_rd, wb_rd;
    logic        stall_f, stall_d, flush_d, flush_x;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fl_left;
    bit          shadow;
    logic [31:0] m_stall, m_flush;
    int          n_fd, n_sd;

    hazard_ctrl #(.REDIRECT_BUBBLES(RB)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_adr1(dec_adr1),
        .dec_adr2(dec_adr2), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_x(flush_x),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        fl_left = 0;
        shadow  = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    function automatic logic [1:0] fwd_of(input logic [4:0] a);
        if (ex_valid && a != 0 && a == ex_rd && !ex_is_load) return 2'b01;
        if (wb_valid && a != 0 && a == wb_rd) return 2'b10;
        return 2'b00;
    endfunction

    // One clock: apply inputs, compare outputs against the model, then advance the model
    task automatic drive(input logic dv, input logic [4:0] a1, input logic [4:0] a2,
                         input logic xv, input logic [4:0] xrd, input logic xl,
                         input logic wv, input logic [4:0] wrd, input logic rd, input logic mb);
        logic [3:0] e_ctl;
        bit         lu, redir_take;
        @(negedge clk);
        dec_valid = dv; dec_adr1 = a1; dec_adr2 = a2;
        ex_valid = xv; ex_rd = xrd; ex_is_load = xl;
        wb_valid = wv; wb_rd = wrd; ex_redirect = rd; mem_busy = mb;
        #1;
        lu = dv && xv && xl && ((a1 != 0 && a1 == xrd) || (a2 != 0 && a2 == xrd));
        redir_take = 1'b0;
        if (mb)               e_ctl = 4'b1100;
        else if (fl_left > 0) e_ctl = 4'b0011;
        else if (rd)          begin e_ctl = 4'b0011; redir_take = 1'b1; end
        else if (!shadow && lu) e_ctl = 4'b1101;
        else                  e_ctl = 4'b0000;
        chk("ctl", {28'd0, stall_f, stall_d, flush_d, flush_x}, {28'd0, e_ctl});
        chk("fwd_a", {30'd0, fwd_a}, {30'd0, fwd_of(a1)});
        chk("fwd_b", {30'd0, fwd_b}, {30'd0, fwd_of(a2)});
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
`else
        chk("stall_cnt", stall_cnt, 32'd0);
        chk("flush_cnt", flush_cnt, 32'd0);
`endif
        n_fd += int'(flush_d);
        n_sd += int'(stall_d);
        @(posedge clk);
        m_stall += 32'(e_ctl[2]);
        m_flush += 32'(e_ctl[1]);
        if (!mb) begin
            if (fl_left > 0)      fl_left--;
            else if (redir_take)  begin fl_left = RB - 1; shadow = 1'b0; end
            else if (!shadow && lu) shadow = 1'b1;
            else                  shadow = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ctl", {28'd0, stall_f, stall_d, flush_d, flush_x}, 32'd0);
        chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        chk("rst_scnt", stall_cnt, 32'd0);
        chk("rst_fcnt", flush_cnt, 32'd0);
    endtask

    initial begin
        int f0, s0;
        rst_n = 1'b0;
        dec_valid = 1'b1; dec_adr1 = 5'd5; dec_adr2 = 5'd5;
        ex_valid = 1'b1; ex_rd = 5'd5; ex_is_load = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd5; ex_redirect = 1'b1; mem_busy = 1'b0;
        n_fd = 0; n_sd = 0;
        model_reset();
        #3;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        ex_redirect = 1'b0;
        idle(1);

        // lw x5 then add x6,x5,x7: one stall, then WB forward with no second stall
        drive(1, 5, 7, 1, 5, 1, 0, 0, 0, 0);
        drive(1, 5, 7, 0, 0, 0, 1, 5, 0, 0);
        drive(1, 5, 7, 1, 5, 1, 0, 0, 0, 0);
        drive(1, 5, 7, 0, 0, 0, 1, 5, 0, 0);
        idle(1);

        // addi x5 then sub x8,x9,x5: EX forward on b only, even with a stale WB hit on b
        drive(1, 9, 5, 1, 5, 0, 1, 5, 0, 0);

        // x0 source against a load to x0
        drive(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);

        // redirect: exactly RB flush cycles
        f0 = n_fd;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(5);
        chk("flush_len", 32'(n_fd - f0), 32'(RB));

        // redirect wins over a simultaneous load-use
        s0 = n_sd;
        drive(1, 5, 0, 1, 5, 1, 0, 0, 1, 0);
        idle(4);
        chk("redir_nostall", 32'(n_sd - s0), 32'd0);

        // mem_busy 4 cycles in the second flush cycle, then the remaining flush
        f0 = n_fd; s0 = n_sd;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        chk("mw_flush", 32'(n_fd - f0), 32'(RB));
        chk("mw_stall", 32'(n_sd - s0), 32'd4);

        // redirect held across mem_busy is taken on exit
        f0 = n_fd;
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        chk("rd_mb_flush", 32'(n_fd - f0), 32'(RB));

        // async reset in the middle of a flush
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        ex_redirect = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // random traffic over small register indices to provoke frequent hits
        for (int i = 0; i < 3000; i++)
            drive(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
